// File: rtl/compute_score_pp_if.sv
// ---------------------------------------------------------------------------
// compute_score_pp_if
// Operand/result bundle for the chaining-score unit.
//   riX, riY : reference positions of anchors i and j (unsigned)
//   qiX, qiY : query positions of anchors i and j (unsigned)
//   W        : window / seed length cap (unsigned)
//   W_avg    : average seed span (unsigned)
//   result   : signed chaining score, driven by the score unit
// Modports: master drives the operands and reads result; slave is the unit.
// ---------------------------------------------------------------------------
interface compute_score_pp_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] riX;
    logic [DATA_W-1:0] riY;
    logic [DATA_W-1:0] qiX;
    logic [DATA_W-1:0] qiY;
    logic [DATA_W-1:0] W;
    logic [DATA_W-1:0] W_avg;
    logic [DATA_W-1:0] result;

    modport master (
        output riX, riY, qiX, qiY, W, W_avg,
        input  result
    );

    modport slave (
        input  riX, riY, qiX, qiY, W, W_avg,
        output result
    );
endinterface

// File: rtl/compute_score_pp.sv
// ---------------------------------------------------------------------------
// compute_score_pp
// Pipelined anchor-chaining score:
//   score = min(dq, dr, W) - (floor(dd*W_avg/GAP_DIV) + (ilog2(dd) >> 1))
// saturated to a signed DATA_W result. One result per clock, in order; the
// result for operands sampled at edge N is visible after edge N+5.
//
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset, clears every stage and result
//   rst_i2f : synchronous active-high flush, clears every stage and result
//   bus     : compute_score_pp_if.slave (operands in, result out)
//
// Build option: define COMPUTE_SCORE_LOG_EN to include the (ilog2(dd) >> 1)
// term in the cost. Without it the cost is the linear term only and the log
// path is absent; stage timing is unchanged.
//
// Stage map (register layer -> content):
//   r0 : sampled operands
//   r1 : dr, dq
//   r2 : m, dd (and lg)
//   r3 : p = dd * W_avg, full width
//   r4 : lin = floor(p / GAP_DIV)
//   r_result : saturated m - cost
// ---------------------------------------------------------------------------
module compute_score_pp #(
    parameter int DATA_W  = 32,
    parameter int GAP_DIV = 100,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rst_i2f,
    compute_score_pp_if.slave bus
);
    localparam int PW  = 2 * DATA_W;     // product width
    localparam int SW  = PW + 2;         // signed score width, covers m - cost
    localparam int LGW = $clog2(DATA_W);

    localparam logic [PW-1:0] DIVC  = PW'(GAP_DIV);
    // floor((2^PW - 1) / GAP_DIV): the estimate p*RECIP >> PW is then either
    // the true quotient or one below it, so a single correction is enough.
    localparam logic [PW-1:0] RECIP = {PW{1'b1}} / DIVC;

    localparam logic signed [SW-1:0] SMAX =
        $signed({{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [SW-1:0] SMIN =
        $signed({{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

    // Stage registers
    logic [DATA_W-1:0] r0_riX, r0_riY, r0_qiX, r0_qiY, r0_w, r0_wavg;
    logic [DATA_W-1:0] r1_dr, r1_dq, r1_w, r1_wavg;
    logic [DATA_W-1:0] r2_m, r2_dd, r2_wavg;
    logic [PW-1:0]     r3_p;
    logic [DATA_W-1:0] r3_m;
    logic [PW-1:0]     r4_lin;
    logic [DATA_W-1:0] r4_m;
    logic [DATA_W-1:0] r_result;

    // Combinational stage logic
    logic [DATA_W-1:0]    w_dr, w_dq, w_m, w_dd;
    logic [PW-1:0]        w_p;
    logic [2*PW-1:0]      w_prod;
    logic [PW-1:0]        w_q0, w_rem, w_lin;
    logic [PW:0]          w_log_term, w_cost;
    logic signed [SW-1:0] w_score;
    logic [DATA_W-1:0]    w_sat;
    logic                 w_unused;

    // Stage 1: absolute coordinate distances
    assign w_dr = (r0_riX >= r0_riY) ? (r0_riX - r0_riY) : (r0_riY - r0_riX);
    assign w_dq = (r0_qiX >= r0_qiY) ? (r0_qiX - r0_qiY) : (r0_qiY - r0_qiX);

    // Stage 2: capped minimum and distance difference
    always_comb begin
        w_m = (r1_dq < r1_dr) ? r1_dq : r1_dr;
        if (r1_w < w_m) w_m = r1_w;
    end
    assign w_dd = (r1_dr >= r1_dq) ? (r1_dr - r1_dq) : (r1_dq - r1_dr);

    // Stage 3: full-width product
    assign w_p = {{DATA_W{1'b0}}, r2_dd} * {{DATA_W{1'b0}}, r2_wavg};

    // Stage 4: exact floor(p / GAP_DIV) via reciprocal and one correction
    assign w_prod = {{PW{1'b0}}, r3_p} * {{PW{1'b0}}, RECIP};
    assign w_q0   = w_prod[2*PW-1:PW];
    assign w_rem  = r3_p - (w_q0 * DIVC);   // q0*DIVC <= p, never wraps
    assign w_lin  = w_q0 + PW'(w_rem >= DIVC);

    // Only the high half of the reciprocal product carries the quotient.
    // LATENCY is descriptive: the depth is fixed by the stage map above.
    assign w_unused = ^{w_prod[PW-1:0], LATENCY[0]};

`ifdef COMPUTE_SCORE_LOG_EN
    logic [LGW-1:0] w_lg, r2_lg, r3_lg, r4_lg;

    // floor(log2 dd); dd = 0 leaves lg at 0
    always_comb begin
        w_lg = '0;
        for (int b = 0; b < DATA_W; b++) begin
            if (w_dd[b]) w_lg = LGW'(b);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r2_lg <= '0;
            r3_lg <= '0;
            r4_lg <= '0;
        end else if (rst_i2f) begin
            r2_lg <= '0;
            r3_lg <= '0;
            r4_lg <= '0;
        end else begin
            r2_lg <= w_lg;
            r3_lg <= r2_lg;
            r4_lg <= r3_lg;
        end
    end

    assign w_log_term = (PW+1)'(r4_lg >> 1);
`else
    assign w_log_term = '0;
`endif

    // Stage 5: cost, wide signed score, saturation
    assign w_cost  = {1'b0, r4_lin} + w_log_term;
    assign w_score = $signed({{(SW-DATA_W){1'b0}}, r4_m})
                   - $signed({{(SW-PW-1){1'b0}}, w_cost});

    always_comb begin
        if (w_score > SMAX)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (w_score < SMIN) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else                     w_sat = w_score[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_riX <= '0; r0_riY <= '0; r0_qiX <= '0; r0_qiY <= '0;
            r0_w   <= '0; r0_wavg <= '0;
            r1_dr  <= '0; r1_dq <= '0; r1_w <= '0; r1_wavg <= '0;
            r2_m   <= '0; r2_dd <= '0; r2_wavg <= '0;
            r3_p   <= '0; r3_m <= '0;
            r4_lin <= '0; r4_m <= '0;
            r_result <= '0;
        end else if (rst_i2f) begin
            r0_riX <= '0; r0_riY <= '0; r0_qiX <= '0; r0_qiY <= '0;
            r0_w   <= '0; r0_wavg <= '0;
            r1_dr  <= '0; r1_dq <= '0; r1_w <= '0; r1_wavg <= '0;
            r2_m   <= '0; r2_dd <= '0; r2_wavg <= '0;
            r3_p   <= '0; r3_m <= '0;
            r4_lin <= '0; r4_m <= '0;
            r_result <= '0;
        end else begin
            r0_riX  <= bus.riX;
            r0_riY  <= bus.riY;
            r0_qiX  <= bus.qiX;
            r0_qiY  <= bus.qiY;
            r0_w    <= bus.W;
            r0_wavg <= bus.W_avg;
            r1_dr   <= w_dr;
            r1_dq   <= w_dq;
            r1_w    <= r0_w;
            r1_wavg <= r0_wavg;
            r2_m    <= w_m;
            r2_dd   <= w_dd;
            r2_wavg <= r1_wavg;
            r3_p    <= w_p;
            r3_m    <= r2_m;
            r4_lin  <= w_lin;
            r4_m    <= r3_m;
            r_result <= w_sat;
        end
    end

    assign bus.result = r_result;
endmodule

// File: tb/tb_compute_score_pp.sv
// ---------------------------------------------------------------------------
// tb_compute_score_pp
// Bench for compute_score_pp: fixed vector table with hand-computed scores,
// back-to-back ordering, flush / async reset corner cases, and a randomized
// stream compared every cycle against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_compute_score_pp;
    typedef longint unsigned u64_t;

    typedef struct {
        logic [31:0] rx, ry, qx, qy, w, wa;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic rst_i2f;

    compute_score_pp_if #(.DATA_W(32)) bus ();

    compute_score_pp #(.DATA_W(32), .GAP_DIV(100), .LATENCY(5)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .rst_i2f (rst_i2f),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    int nvec = 0;
    int nmis = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_score(input vec_t v);
        longint dr, dq, m, dd, lg, cost, s;
        u64_t   p;
        dr = (v.rx > v.ry) ? longint'(v.rx) - longint'(v.ry) : longint'(v.ry) - longint'(v.rx);
        dq = (v.qx > v.qy) ? longint'(v.qx) - longint'(v.qy) : longint'(v.qy) - longint'(v.qx);
        m = dr;
        if (dq < m) m = dq;
        if (longint'(v.w) < m) m = longint'(v.w);
        dd = (dr > dq) ? dr - dq : dq - dr;
        lg = 0;
        while ((longint'(1) << (lg + 1)) <= dd) lg++;
        p = u64_t'(dd) * u64_t'(v.wa);
        cost = longint'(p / 64'd100);
`ifdef COMPUTE_SCORE_LOG_EN
        cost = cost + lg / 2;
`endif
        s = m - cost;
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    // Operands and kill (flush or reset) recorded at every rising edge.
    vec_t hin   [0:4095];
    bit   hkill [0:4095];
    int   ecnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (ecnt < 4095) ecnt++;
            hin[ecnt].rx  = bus.riX;
            hin[ecnt].ry  = bus.riY;
            hin[ecnt].qx  = bus.qiX;
            hin[ecnt].qy  = bus.qiY;
            hin[ecnt].w   = bus.W;
            hin[ecnt].wa  = bus.W_avg;
            hin[ecnt].exp = '0;
            hkill[ecnt]   = rst_i2f || !rst_n;
        end
    end

    // Expected result after edge ecnt: operands from 5 edges earlier, unless
    // any kill hit the item somewhere on its way through.
    function automatic logic [31:0] exp_now();
        if (!rst_n) return '0;
        if (ecnt < 6) return '0;
        for (int k = ecnt - 5; k <= ecnt; k++) begin
            if (hkill[k]) return '0;
        end
        return ref_score(hin[ecnt - 5]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, ecnt);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model", bus.result, exp_now());
    endtask

    task automatic set_in(input vec_t v);
        bus.riX   = v.rx;
        bus.riY   = v.ry;
        bus.qiX   = v.qx;
        bus.qiY   = v.qy;
        bus.W     = v.w;
        bus.W_avg = v.wa;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom);
            1:       return 32'($urandom_range(0, 2000));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            3:       return 32'h8000_0000 + 32'($urandom_range(0, 3000));
            default: return 32'($urandom_range(0, 5));
        endcase
    endfunction

    vec_t tab [6];
    vec_t rv;

    initial begin
        tab[0] = '{100, 30, 50, 20, 40, 40,
`ifdef COMPUTE_SCORE_LOG_EN
                   32'd12};
`else
                   32'd14};
`endif
        tab[1] = '{100, 50, 80, 30, 100, 20, 32'd50};
        tab[2] = '{1000, 0, 1000, 1, 10, 0, 32'd10};
        tab[3] = '{0, 1000, 0, 10, 100, 100,
`ifdef COMPUTE_SCORE_LOG_EN
                   32'hFFFF_FC28};
`else
                   32'hFFFF_FC2C};
`endif
        tab[4] = '{32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 5, 32'h7FFF_FFFF};
        tab[5] = '{32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h8000_0000};

        rst_n   = 1'b0;
        rst_i2f = 1'b0;
        set_in(tab[0]);
        #1 chk("reset_state", bus.result, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        // Flush, release, result appears exactly 5 edges after first sample
        for (int i = 0; i < 6; i++) begin
            set_in(tab[i]);
            rst_i2f = 1'b1;
            tick();
            tick();
            chk("flush_hold", bus.result, 32'd0);
            rst_i2f = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (k == 5) chk("latency_early", bus.result, 32'd0);
                if (k == 6) chk($sformatf("vec%0d", i), bus.result, tab[i].exp);
            end
        end

        // Back-to-back vectors, results in order 5 edges after each sample
        for (int i = 0; i < 9; i++) begin
            if (i < 4) set_in(tab[i]);
            tick();
            if (i >= 5) chk($sformatf("b2b%0d", i - 5), bus.result, tab[i - 5].exp);
        end

        // Random stream with occasional flushes
        for (int i = 0; i < 400; i++) begin
            rv = '{rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 32'd0};
            set_in(rv);
            rst_i2f = ($urandom_range(0, 31) == 0);
            tick();
        end
        rst_i2f = 1'b0;
        repeat (6) tick();

        // Mid-stream flush
        rst_i2f = 1'b1;
        tick();
        chk("flush_mid", bus.result, 32'd0);
        rst_i2f = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rv = '{rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 32'd0};
            set_in(rv);
            tick();
        end

        // Mid-stream async reset, cleared with no clock edge
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_async", bus.result, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        set_in(tab[3]);
        repeat (6) tick();
        chk("rst_recover", bus.result, tab[3].exp);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
